// File: rtl/simuart_mmio_pkg.sv
// Shared register offsets, LSR bit positions and the MMIO request layout for the
// simulation UART.
package simuart_mmio_pkg;

    localparam logic [2:0] UART_THR_OFF = 3'd0;
    localparam logic [2:0] UART_LSR_OFF = 3'd5;

    localparam int LSR_DR     = 0;
    localparam int LSR_THRE   = 5;
    localparam int LSR_TEMT   = 6;
    localparam int LSR_TXDROP = 7;

    localparam logic [7:0] UART_NO_CHAR = 8'hFF;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
    } mmio_req_t;

    function automatic logic [7:0] lsr_pack(input logic txdrop, input logic temt,
                                            input logic thre, input logic dr);
        logic [7:0] v;
        v             = 8'h00;
        v[LSR_TXDROP] = txdrop;
        v[LSR_TEMT]   = temt;
        v[LSR_THRE]   = thre;
        v[LSR_DR]     = dr;
        return v;
    endfunction

endpackage

// File: rtl/simuart_mmio_sync_fifo.sv
// Generic synchronous FIFO with the head entry read straight from the storage registers.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: none internally; the caller must only push when !full or when popping.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: pointer reset alone discards the contents.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/simuart_mmio.sv
// 8250-style MMIO console bridging CPU byte accesses to difftest uart ports.
// Latency: response 1 cycle after request; TX char appears 1 cycle after its FIFO pop.
// Backpressure: none on MMIO; THR writes to a full FIFO are dropped and flagged in LSR.
module simuart_mmio
    import simuart_mmio_pkg::*;
#(
    parameter int TX_DEPTH      = 16,
    parameter int TX_GAP        = 0,
    parameter int POLL_INTERVAL = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_we,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       io_uart_out_valid,
    output logic [7:0] io_uart_out_ch,
    output logic       io_uart_in_valid,
    input  logic [7:0] io_uart_in_ch
);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
    localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(TX_GAP);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

    mmio_req_t     req;
    logic          thr_wr;
    logic          rbr_rd;
    logic          lsr_rd;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_pop;
    logic          tx_push;
    logic          tx_drop;
    logic [CW-1:0] tx_count;
    logic [7:0]    tx_head;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    rbr;
    logic          dr;
    logic          txdrop;
    logic          out_vld_q;
    logic          poll;
    logic          temt;
    logic [7:0]    rdata_nxt;

    assign req    = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign thr_wr = req_valid &&  req.we && (req.addr == UART_THR_OFF);
    assign rbr_rd = req_valid && !req.we && (req.addr == UART_THR_OFF);
    assign lsr_rd = req_valid && !req.we && (req.addr == UART_LSR_OFF);

    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    assign tx_pop  = !tx_empty && (gap_cnt == '0);
    assign tx_push = thr_wr && (!tx_full || tx_pop);
    assign tx_drop = thr_wr && tx_full && !tx_pop;
    assign temt    = (tx_count == '0) && (gap_cnt == '0);

    assign poll = !dr && (poll_cnt == '0);

    // Gated so no pulse can leak out during a reset cycle.
    assign io_uart_out_valid = out_vld_q && !reset;
    assign io_uart_in_valid  = poll && !reset;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (tx_push),
        .push_dat (req.wdata),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    always_comb begin
        rdata_nxt = 8'h00;
        if (req_valid && !req.we) begin
            case (req.addr)
                UART_THR_OFF: rdata_nxt = rbr;
                UART_LSR_OFF: rdata_nxt = lsr_pack(txdrop, temt, !tx_full, dr);
                default:      rdata_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid     <= 1'b0;
            resp_rdata     <= 8'h00;
            out_vld_q      <= 1'b0;
            io_uart_out_ch <= 8'h00;
            gap_cnt        <= '0;
            txdrop         <= 1'b0;
        end else begin
            resp_valid <= req_valid;
            resp_rdata <= rdata_nxt;
            out_vld_q  <= tx_pop;
            if (tx_pop) io_uart_out_ch <= tx_head;

            if (tx_pop)               gap_cnt <= GAP_RELOAD;
            else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GW'(1);

            if (tx_drop)     txdrop <= 1'b1;
            else if (lsr_rd) txdrop <= 1'b0;
        end
    end

    // RX poller: poll and RBR-read never collide on DR since polls only run with DR=0.
    always_ff @(posedge clock) begin
        if (reset) begin
            rbr      <= 8'h00;
            dr       <= 1'b0;
            poll_cnt <= POLL_RELOAD;
        end else begin
            if (rbr_rd) dr <= 1'b0;
            if (poll) begin
                poll_cnt <= POLL_RELOAD;
                if (io_uart_in_ch != UART_NO_CHAR) begin
                    rbr <= io_uart_in_ch;
                    dr  <= 1'b1;
                end
            end else if (dr) begin
                poll_cnt <= POLL_RELOAD;
            end else begin
                poll_cnt <= poll_cnt - PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_simuart_mmio.sv
// Scoreboard bench for simuart_mmio: two instances (TX_GAP 0 and 4) share one stimulus stream.
module tb_simuart_mmio;
    localparam int POLL = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid0, resp_valid4;
    logic [7:0] resp_rdata0, resp_rdata4;
    logic       out_valid0, out_valid4;
    logic [7:0] out_ch0, out_ch4;
    logic       in_valid0, in_valid4;
    logic [7:0] io_uart_in_ch;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic req_seen  = 1'b0;
    logic poll_flag = 1'b0;
    logic rx_force  = 1'b1;

    logic [7:0] q_resp0[$], q_resp4[$], q_out0[$], q_out4[$], rx_q[$];
    int t_out0[$], t_out4[$], t_poll0[$], t_poll4[$];

    always #5 clock = ~clock;

    simuart_mmio #(.TX_DEPTH(16), .TX_GAP(0), .POLL_INTERVAL(POLL)) u_dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .io_uart_out_valid(out_valid0), .io_uart_out_ch(out_ch0),
        .io_uart_in_valid(in_valid0), .io_uart_in_ch(io_uart_in_ch));

    simuart_mmio #(.TX_DEPTH(16), .TX_GAP(4), .POLL_INTERVAL(POLL)) u_dut4 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid4),
        .resp_rdata(resp_rdata4), .io_uart_out_valid(out_valid4), .io_uart_out_ch(out_ch4),
        .io_uart_in_valid(in_valid4), .io_uart_in_ch(io_uart_in_ch));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1000;
    endfunction

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        req_seen <= req_valid;
    end

    // RX reply script: one entry per poll, 8'hFF once the script runs dry.
    always @(posedge clock) begin
        if (poll_flag && rx_q.size() != 0) void'(rx_q.pop_front());
        #1;
        io_uart_in_ch = rx_force ? 8'h41 : ((rx_q.size() != 0) ? rx_q[0] : 8'hFF);
    end

    always @(negedge clock) begin
        poll_flag <= in_valid0;
        if (in_valid0) t_poll0.push_back(cyc);
        if (in_valid4) t_poll4.push_back(cyc);
        if (!reset) begin
            if (req_seen || resp_valid0) chk("resp_valid0_timing", resp_valid0, req_seen);
            if (req_seen || resp_valid4) chk("resp_valid4_timing", resp_valid4, req_seen);
            if (resp_valid0) begin
                chk("resp0_pending", q_resp0.size() != 0, 1);
                if (q_resp0.size() != 0) chk("resp0_rdata", resp_rdata0, q_resp0.pop_front());
            end
            if (resp_valid4) begin
                chk("resp4_pending", q_resp4.size() != 0, 1);
                if (q_resp4.size() != 0) chk("resp4_rdata", resp_rdata4, q_resp4.pop_front());
            end
        end
        if (out_valid0) begin
            chk("out0_pending", q_out0.size() != 0, 1);
            if (q_out0.size() != 0) chk("out0_ch", out_ch0, q_out0.pop_front());
            t_out0.push_back(cyc);
        end
        if (out_valid4) begin
            chk("out4_pending", q_out4.size() != 0, 1);
            if (q_out4.size() != 0) chk("out4_ch", out_ch4, q_out4.pop_front());
            t_out4.push_back(cyc);
        end
    end

    // One request per call; caller is at posedge+1 and returns there one cycle later.
    task automatic mmio(input logic we, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] e0, input logic [7:0] e4);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        q_resp0.push_back(we ? 8'h00 : e0);
        q_resp4.push_back(we ? 8'h00 : e4);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rel_cyc;
        int rd_cyc;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 3'd0; req_wdata = 8'h00;
        reset = 1'b1;

        // Reset state with the bench offering 8'h41 throughout.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("rst_outputs0", {resp_valid0, resp_rdata0, out_valid0, out_ch0, in_valid0}, 0);
            chk("rst_outputs4", {resp_valid4, resp_rdata4, out_valid4, out_ch4, in_valid4}, 0);
        end
        #1;
        reset    = 1'b0;
        rx_force = 1'b0;
        rel_cyc  = cyc;
        @(negedge clock);
        chk("post_rst_pulses", {out_valid0, in_valid0, out_valid4, in_valid4}, 0);
        @(posedge clock);
        #1;
        mmio(1'b0, 3'd5, 8'h00, 8'h60, 8'h60);
        idle(0);
        for (int i = 0; i < 40 && t_poll0.size() < 1; i++) idle(1);
        // Counter starts at POLL-1, so the poll fills the POLL-th cycle after release.
        chk("first_poll0_cycle", at(t_poll0, 0) - rel_cyc, POLL - 1);
        chk("first_poll4_cycle", at(t_poll4, 0) - rel_cyc, POLL - 1);

        // RX: two empty polls then 'z'.
        rx_q.push_back(8'hFF); rx_q.push_back(8'hFF); rx_q.push_back(8'h7A);
        for (int i = 0; i < 60 && t_poll0.size() < 4; i++) idle(1);
        chk("rx_polls_seen", t_poll0.size(), 4);
        chk("rx_poll_spacing", at(t_poll0, 3) - at(t_poll0, 2), POLL);
        idle(2);
        mmio(1'b0, 3'd5, 8'h00, 8'h61, 8'h61);
        idle(3 * POLL);
        chk("rx_polls_stopped0", t_poll0.size(), 4);
        chk("rx_polls_stopped4", t_poll4.size(), 4);
        rd_cyc = cyc;
        mmio(1'b0, 3'd0, 8'h00, 8'h7A, 8'h7A);
        mmio(1'b0, 3'd5, 8'h00, 8'h60, 8'h60);
        idle(0);
        for (int i = 0; i < 40 && t_poll0.size() < 5; i++) idle(1);
        chk("rx_resume0", at(t_poll0, 4) - rd_cyc, POLL);
        chk("rx_resume4", at(t_poll4, 4) - rd_cyc, POLL);

        // Write burst "Hi\n".
        t_out0.delete(); t_out4.delete();
        mmio(1'b1, 3'd0, 8'h48, 8'h00, 8'h00); q_out0.push_back(8'h48); q_out4.push_back(8'h48);
        mmio(1'b1, 3'd0, 8'h69, 8'h00, 8'h00); q_out0.push_back(8'h69); q_out4.push_back(8'h69);
        mmio(1'b1, 3'd0, 8'h0A, 8'h00, 8'h00); q_out0.push_back(8'h0A); q_out4.push_back(8'h0A);
        idle(30);
        chk("burst_count0", t_out0.size(), 3);
        chk("burst_back2back_a", at(t_out0, 1) - at(t_out0, 0), 1);
        chk("burst_back2back_b", at(t_out0, 2) - at(t_out0, 1), 1);
        chk("burst_gap4", at(t_out4, 2) - at(t_out4, 1), 5);
        chk("out_ch_hold", out_ch0, 8'h0A);
        mmio(1'b0, 3'd5, 8'h00, 8'h60, 8'h60);

        // Overflow: 24 back-to-back writes; the gap-4 instance drops 20, 22, 23
        // and keeps 21 because a pop coincides with that write.
        idle(2);
        t_out0.delete(); t_out4.delete();
        for (int b = 0; b < 24; b++) begin
            mmio(1'b1, 3'd0, 8'(b), 8'h00, 8'h00);
            q_out0.push_back(8'(b));
            if (b <= 19 || b == 21) q_out4.push_back(8'(b));
        end
        idle(130);
        chk("ovf_count0", t_out0.size(), 24);
        chk("ovf_count4", t_out4.size(), 21);
        for (int i = 0; i < 20; i++) chk("ovf_spacing4", at(t_out4, i + 1) - at(t_out4, i), 5);
        chk("ovf_pending4", q_out4.size(), 0);
        mmio(1'b0, 3'd5, 8'h00, 8'h60, 8'hE0);
        mmio(1'b0, 3'd5, 8'h00, 8'h60, 8'h60);

        // Unmapped offset 3.
        idle(2);
        t_out0.delete(); t_out4.delete();
        mmio(1'b0, 3'd3, 8'h00, 8'h00, 8'h00);
        mmio(1'b1, 3'd3, 8'h55, 8'h00, 8'h00);
        idle(12);
        chk("unmapped_no_out", t_out0.size() + t_out4.size(), 0);

        // Reset mid-drain: gap-4 instance has sent only 2 of 8 when reset hits.
        t_out0.delete(); t_out4.delete();
        for (int b = 0; b < 8; b++) begin
            mmio(1'b1, 3'd0, 8'hA0 + 8'(b), 8'h00, 8'h00);
            q_out0.push_back(8'hA0 + 8'(b));
            if (b < 2) q_out4.push_back(8'hA0 + 8'(b));
        end
        idle(0);
        for (int i = 0; i < 40 && !(t_out4.size() >= 2 && q_out0.size() == 0); i++) idle(1);
        chk("middrain_pre_reset4", t_out4.size(), 2);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        mmio(1'b0, 3'd5, 8'h00, 8'h60, 8'h60);
        idle(40);
        chk("middrain_count0", t_out0.size(), 8);
        chk("middrain_count4", t_out4.size(), 2);

        chk("final_out_q", q_out0.size() + q_out4.size(), 0);
        chk("final_resp_q", q_resp0.size() + q_resp4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
